// File: rtl/rr_slot_arb_pkg.sv
// rr_slot_arb_pkg: shared state type, width helpers and round-robin pick
package rr_slot_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_e;

    function automatic int wmin1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    // First requester at or after ptr (mod n); -1 when nobody requests
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int r;
        int j;
        r = -1;
        for (int i = 0; i < 32; i++) begin
            j = (ptr + i) % n;
            if (i < n && r < 0 && req[j]) r = j;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_slot_arb_slot_cntr.sv
// slot_cntr: modulo-SLOT cycle counter with clear and terminal count
module slot_cntr
    import rr_slot_arb_pkg::*;
#(
    parameter int SLOT = 8,
    localparam int CW = wmin1(SLOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = cnt_q == CW'(SLOT - 1);

    // Clear wins over increment; increment wraps at the terminal count
    always_comb begin
        cnt_d = clr ? '0 : inc ? (tc ? '0 : cnt_q + CW'(1)) : cnt_q;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rr_slot_arb.sv
// rr_slot_arb: round-robin time-sliced arbiter with early release
module rr_slot_arb
    import rr_slot_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int SLOT = 8,
    localparam int IDW = wmin1(N),
    localparam int CW = wmin1(SLOT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic [CW-1:0]  slot_cnt,
    output logic           expire
);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           exp_q, exp_d;
    logic           term, start, clr, inc, tc;

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = |gnt_q;
    assign expire = exp_q;

    slot_cntr #(.SLOT(SLOT)) u_cntr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .cnt (slot_cnt),
        .tc  (tc)
    );

    // Termination, pointer advance and hand-over to the next owner in one step
    always_comb begin
        int p;
        term    = state_q == GRANT && (rel || !req[id_q] || tc);
        ptr_d   = term ? IDW'((int'(id_q) + 1) % N) : ptr_q;
        p       = rr_pick(32'(req), int'(ptr_d), N);
        start   = en && p >= 0 && (state_q == IDLE || term);
        state_d = start ? GRANT : term ? IDLE : state_q;
        gnt_d   = start ? N'(1) << p : term ? '0 : gnt_q;
        id_d    = start ? IDW'(p) : term ? '0 : id_q;
        exp_d   = term && !rel && req[id_q];
        clr     = state_q == IDLE || term;
        inc     = state_q == GRANT && !term;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            exp_q   <= exp_d;
        end
    end

endmodule

// File: doc/rr_slot_arb.md
Name: rr_slot_arb

Overview:
Round-robin, time-sliced arbiter that shares one resource among N requesters. Each grant lasts at most SLOT cycles, timed by an internal modulo slot counter. The owner may release early, or lose the grant by dropping its request. Sits between requesting engines and a shared datapath; drives the grant vector and the slot timebase.

Parameters:
N, 4, number of requesters (>=2); IDW = max(1, $clog2(N))
SLOT, 8, maximum grant length in cycles (>=1); CW = max(1, $clog2(SLOT))

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  allow new grants; does not affect a grant already in progress
req  input  N  per-requester request level
rel  input  1  early release by the current owner; ignored when busy=0
gnt  output  N  one-hot grant, registered
gnt_id  output  IDW  index of the current owner; 0 when idle
busy  output  1  grant active (equals |gnt)
slot_cnt  output  CW  cycles elapsed in the current grant, 0..SLOT-1
expire  output  1  one-cycle pulse: the previous grant ended by slot limit

Behaviour:
- Reset (rst=1 at an edge): gnt=0, gnt_id=0, busy=0, slot_cnt=0, expire=0, ptr=0, state=IDLE.
  - Reset overrides all other events, including mid-grant.
- State machine IDLE/GRANT. All outputs are registered.
- Pick rule: choose the first i with req[i]=1, searching ptr, ptr+1, ... mod N.
- IDLE:
  - If en=1 and |req=1 at an edge, go to GRANT.
  - gnt=onehot(pick), gnt_id=pick, slot_cnt=0.
  - Latency: req sampled at edge t gives gnt high after edge t (visible in cycle t+1).
- GRANT, each edge: the grant terminates if any of these holds for owner k:
  - rel=1;
  - req[k]=0;
  - slot_cnt==SLOT-1.
- GRANT, no termination: slot_cnt increments by 1.
- GRANT, on termination:
  - ptr <= (k+1) mod N.
  - The pick is evaluated using the new ptr against the current req.
  - If en=1 and a pick exists: stay in GRANT with the new owner, slot_cnt=0, no idle bubble.
  - Otherwise: go to IDLE, gnt=0, gnt_id=0, slot_cnt=0.
- The previous owner may be re-granted only if it is the sole requester, since it is searched last.
- expire: 1 for the cycle after a termination caused solely by the slot limit (rel=0, req[k]=1). Otherwise 0.
  - expire and a new gnt may be high in the same cycle.
- SLOT=1: every grant lasts exactly one cycle; expire follows each one unless rel=1.
- Simultaneous rel and slot limit: counts as a release, expire=0.
- en=0: no new grants are issued. A current grant runs until it terminates, then the block goes IDLE.
- Changes to req of non-owners during a grant have no effect until the next pick.
- slot_cnt wraps only by termination; it never exceeds SLOT-1.

Decomposition:
- Shared package: state enum {IDLE, GRANT}, and width helpers for IDW and CW.
- One sub-module, slot_cntr: modulo-SLOT counter.
  - Inputs: clk, rst, clr, inc.
  - Outputs: cnt and tc (tc = cnt==SLOT-1).
- The round-robin pick is a function in the package.

Test Plan:
1. Hold rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_id=0, busy=0, slot_cnt=0, expire=0 throughout.
2. en=1, req=4'b0100 held, rel=0 -> gnt=4'b0100 one cycle later, slot_cnt 0..7. Next cycle: expire=1, gnt=4'b0100 again (sole requester), slot_cnt=0.
3. en=1, req=4'b1111 held, rel pulsed when slot_cnt=2 -> owners 0,1,2,3,0 in turn, each gnt lasting 3 cycles, no gaps, expire never 1.
4. Owner 1 drops req[1] at slot_cnt=4 with req[3]=1 pending -> next cycle gnt=4'b1000, gnt_id=3, slot_cnt=0, expire=0.
5. Owner 0 active, en=0, req=4'b0011 -> owner 0 runs to slot_cnt=7, then expire=1, gnt=0, busy=0. Set en=1 -> gnt=4'b0010 next cycle.
6. rst=1 for one edge while gnt=4'b0100, slot_cnt=5 -> next cycle all outputs 0. Release rst with req=4'b0100 -> gnt=4'b0100 one cycle later (search from ptr=0).
